// File: rtl/peripheral_biu_pkg.sv
// Shared BIU encodings, burst helpers and the SPRAM bridge FSM state type.
package peripheral_biu_pkg;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HWORD = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_ERR} spram_bridge_state_t;

  function automatic logic hburst_valid(logic [2:0] hb);
    case (hb)
      HBURST_SINGLE, HBURST_INCR, HBURST_WRAP4, HBURST_INCR4,
      HBURST_WRAP8, HBURST_INCR8, HBURST_WRAP16, HBURST_INCR16: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] burst_len(logic [2:0] hb);
    case (hb)
      HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
      HBURST_WRAP16, HBURST_INCR16: return 5'd16;
      default:                      return 5'd1;
    endcase
  endfunction

  function automatic logic is_wrap(logic [2:0] hb);
    return (hb == HBURST_WRAP4) || (hb == HBURST_WRAP8) || (hb == HBURST_WRAP16);
  endfunction

  // Next beat: step to the following word; wraps stay inside the N-word block.
  function automatic logic [63:0] next_addr(logic [63:0] a, logic [2:0] hb, logic [63:0] bytes);
    logic [63:0] inc, blk;
    inc = (a & ~(bytes - 64'd1)) + bytes;
    blk = 64'(burst_len(hb)) * bytes;
    if (is_wrap(hb)) return (a & ~(blk - 64'd1)) | (inc & (blk - 64'd1));
    return inc;
  endfunction

endpackage

// File: rtl/peripheral_spram_bridge_delay.sv
// Clearable shift register of DEPTH stages carrying {valid, addr} alongside the RAM latency.
module peripheral_spram_bridge_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] dl_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_pipe <= '0;
    end else begin
      dl_pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) dl_pipe[i] <= dl_pipe[i-1];
    end
  end

  assign q = dl_pipe[DEPTH-1];

endmodule

// File: rtl/peripheral_spram_bridge_biu_pipe.sv
// BIU to single-port RAM bridge: per-beat requests, byte enables, latency-matched acks.
// Optional start-address window check: define SPRAM_BRIDGE_RANGE_CHECK_EN.
module peripheral_spram_bridge_biu_pipe
  import peripheral_biu_pkg::*;
#(
  parameter int          XLEN        = 64,
  parameter int          PLEN        = 64,
  parameter int          RAM_LATENCY = 1,
  parameter logic [63:0] MEM_BASE    = 64'h0,
  parameter logic [63:0] MEM_SIZE    = 64'h10000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [XLEN/8-1:0] ram_be_o,
  output logic [PLEN-1:0]   ram_addr_o,
  output logic [XLEN-1:0]   ram_d_o,
  input  logic [XLEN-1:0]   ram_q_i,
  input  logic              biu_stb_i,
  output logic              biu_stb_ack_o,
  output logic              biu_d_ack_o,
  input  logic [PLEN-1:0]   biu_adri_i,
  output logic [PLEN-1:0]   biu_adro_o,
  input  logic [2:0]        biu_size_i,
  input  logic [2:0]        biu_type_i,
  input  logic [2:0]        biu_prot_i,
  input  logic              biu_lock_i,
  input  logic              biu_we_i,
  input  logic [XLEN-1:0]   biu_d_i,
  output logic [XLEN-1:0]   biu_q_o,
  output logic              biu_ack_o,
  output logic              biu_err_o
);

  localparam int          BYTES   = XLEN / 8;
  localparam int          SZ_MAX  = $clog2(BYTES);
  localparam logic [63:0] BYTES64 = 64'(BYTES);

  spram_bridge_state_t state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [2:0]       hburst_r;
  logic             we_r;
  logic             accept, bad, size_bad, misal, range_bad, err_nx;
  logic             beat_vld, beat_we;
  logic [PLEN-1:0]  beat_addr;
  logic [BYTES-1:0] beat_be, first_be;
  logic [4:0]       len;
  logic [PLEN:0]    dl_q;

  logic unused_in;
  assign unused_in = ^{biu_prot_i, biu_lock_i};

`ifdef SPRAM_BRIDGE_RANGE_CHECK_EN
  localparam logic [PLEN:0] RANGE_LO = (PLEN+1)'(MEM_BASE);
  localparam logic [PLEN:0] RANGE_HI = RANGE_LO + (PLEN+1)'(MEM_SIZE);
  assign range_bad = ({1'b0, biu_adri_i} < RANGE_LO) || ({1'b0, biu_adri_i} >= RANGE_HI);
`else
  logic unused_range;
  assign unused_range = ^{MEM_BASE, MEM_SIZE};
  assign range_bad    = 1'b0;
`endif

  assign len      = burst_len(biu_type_i);
  assign size_bad = biu_size_i > 3'(SZ_MAX);
  assign misal    = |(biu_adri_i & PLEN'((64'd1 << biu_size_i) - 64'd1));
  assign bad      = size_bad | misal | ~hburst_valid(biu_type_i) | range_bad;

  // 2^size lanes starting at the in-word offset; full-word and larger enable every lane
  always_comb begin
    if (biu_size_i >= 3'(SZ_MAX)) first_be = '1;
    else first_be = BYTES'((32'd1 << (32'd1 << biu_size_i)) - 32'd1) << biu_adri_i[SZ_MAX-1:0];
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    accept        = 1'b0;
    biu_stb_ack_o = 1'b0;
    biu_d_ack_o   = 1'b0;
    beat_vld      = 1'b0;
    beat_we       = we_r;
    beat_addr     = ram_addr_o;
    beat_be       = '1;
    err_nx        = 1'b0;
    case (state)
      ST_IDLE: begin
        biu_stb_ack_o = biu_stb_i;
        if (biu_stb_i) begin
          accept      = 1'b1;
          biu_d_ack_o = 1'b1;
          if (bad) begin
            state_nx = ST_ERR;
            err_nx   = 1'b1;
          end else begin
            beat_vld  = 1'b1;
            beat_we   = biu_we_i;
            beat_addr = biu_adri_i;
            beat_be   = first_be;
            if (len != 5'd1) begin
              state_nx = ST_BURST;
              cnt_nx   = 4'(len - 5'd1);
            end
          end
        end
      end
      ST_BURST: begin
        biu_d_ack_o = 1'b1;
        beat_vld    = 1'b1;
        beat_addr   = PLEN'(next_addr(64'(ram_addr_o), hburst_r, BYTES64));
        cnt_nx      = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = ST_IDLE;
      end
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hburst_r   <= '0;
      we_r       <= 1'b0;
      ram_req_o  <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_be_o   <= '0;
      ram_addr_o <= '0;
      ram_d_o    <= '0;
      biu_err_o  <= 1'b0;
    end else begin
      ram_req_o <= beat_vld;
      biu_err_o <= err_nx;
      if (accept) begin
        hburst_r <= biu_type_i;
        we_r     <= biu_we_i;
      end
      if (biu_d_ack_o) ram_d_o <= biu_d_i;
      if (beat_vld) begin
        ram_addr_o <= beat_addr;
        ram_be_o   <= beat_be;
        ram_we_o   <= beat_we;
      end
    end
  end

  peripheral_spram_bridge_delay #(.DEPTH(RAM_LATENCY), .WIDTH(PLEN + 1)) u_delay (
    .clk (clk),
    .rst (rst),
    .d   ({ram_req_o, ram_addr_o}),
    .q   (dl_q)
  );

  assign biu_ack_o  = dl_q[PLEN];
  assign biu_adro_o = dl_q[PLEN-1:0];
  assign biu_q_o    = biu_ack_o ? ram_q_i : '0;

endmodule

// File: tb/tb_peripheral_spram_bridge_biu_pipe.sv
// Random + directed bench: transaction-level model predicts every output per cycle.
module tb_peripheral_spram_bridge_biu_pipe;

  localparam int          LAT   = 3;
  localparam logic [63:0] MSIZE = 64'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_req_o, ram_we_o;
  logic [7:0]  ram_be_o;
  logic [63:0] ram_addr_o, ram_d_o, ram_q_i;
  logic        biu_stb_i, biu_stb_ack_o, biu_d_ack_o;
  logic [63:0] biu_adri_i, biu_adro_o, biu_d_i, biu_q_o;
  logic [2:0]  biu_size_i, biu_type_i, biu_prot_i;
  logic        biu_lock_i, biu_we_i, biu_ack_o, biu_err_o;

  always #5 clk = ~clk;

  peripheral_spram_bridge_biu_pipe #(
    .XLEN(64), .PLEN(64), .RAM_LATENCY(LAT), .MEM_BASE(64'h0), .MEM_SIZE(MSIZE)
  ) dut (
    .clk(clk), .rst(rst),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_addr_o(ram_addr_o), .ram_d_o(ram_d_o), .ram_q_i(ram_q_i),
    .biu_stb_i(biu_stb_i), .biu_stb_ack_o(biu_stb_ack_o), .biu_d_ack_o(biu_d_ack_o),
    .biu_adri_i(biu_adri_i), .biu_adro_o(biu_adro_o),
    .biu_size_i(biu_size_i), .biu_type_i(biu_type_i), .biu_prot_i(biu_prot_i),
    .biu_lock_i(biu_lock_i), .biu_we_i(biu_we_i), .biu_d_i(biu_d_i),
    .biu_q_o(biu_q_o), .biu_ack_o(biu_ack_o), .biu_err_o(biu_err_o)
  );

  typedef struct packed {
    logic [31:0]       id;
    logic [63:0]       addr;
    logic [2:0]        size;
    logic [2:0]        hb;
    logic              we;
    logic [15:0][63:0] data;
  } txn_t;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int next_free = 0;
  int t3 = 0;
  int ridx;

  // expectations keyed by cycle number
  bit          e_req[int], e_dack[int], e_sack[int], e_err[int], e_ack[int], e_qv[int];
  logic [63:0] e_addr[int], e_be[int], e_we[int], e_wd[int], e_adro[int], e_q[int];
  logic [63:0] q_sched[int], d_plan[int];
  logic [63:0] ref_mem[1024];
  logic [63:0] ram_mem[1024];

  txn_t q[$];
  txn_t cur;
  bit   pending = 0;
  int   gap = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_accept(input txn_t t, input int tc);
    int n, c, idx;
    bit bad;
    logic [63:0] blk, base, w0, a, be;
    n = (t.hb < 3'd2) ? 1 : (t.hb < 3'd4) ? 4 : (t.hb < 3'd6) ? 8 : 16;
    bad = (t.size > 3'd3) || ((t.addr % (64'd1 << t.size)) != 64'd0);
`ifdef SPRAM_BRIDGE_RANGE_CHECK_EN
    if (t.addr >= MSIZE) bad = 1;
`endif
    e_dack[tc] = 1;
    e_sack[tc] = 1;
    if (bad) begin
      e_err[tc+1] = 1;
      next_free = tc + 2;
      return;
    end
    blk  = 64'(n) * 64'd8;
    base = t.addr - (t.addr % blk);
    w0   = (t.addr % blk) / 64'd8;
    for (int k = 0; k < n; k++) begin
      if (k == 0) a = t.addr;
      else if (t.hb == 3'd2 || t.hb == 3'd4 || t.hb == 3'd6)
        a = base + ((w0 + 64'(k)) % 64'(n)) * 64'd8;
      else a = (t.addr / 64'd8 + 64'(k)) * 64'd8;
      be = (k == 0 && t.size < 3'd3) ? (((64'd1 << (1 << t.size)) - 64'd1) << (a % 64'd8)) : 64'hFF;
      e_dack[tc+k] = 1;
      if (k > 0) d_plan[tc+k] = t.data[k];
      c = tc + 1 + k;
      e_req[c] = 1; e_addr[c] = a; e_be[c] = be; e_we[c] = 64'(t.we);
      idx = int'((a / 64'd8) % 64'd1024);
      if (t.we) begin
        e_wd[c] = t.data[k];
        for (int b = 0; b < 8; b++) if (be[b]) ref_mem[idx][b*8 +: 8] = t.data[k][b*8 +: 8];
      end else begin
        e_qv[c+LAT] = 1;
        e_q[c+LAT]  = ref_mem[idx];
      end
      e_ack[c+LAT]  = 1;
      e_adro[c+LAT] = a;
    end
    next_free = tc + n;
  endtask

  // hand-computed values that pin the model on the directed transactions
  task automatic pins(input txn_t t, input int tc);
    logic [63:0] wa[4];
    wa[0] = 64'h18; wa[1] = 64'h00; wa[2] = 64'h08; wa[3] = 64'h10;
    case (t.id)
      0: begin
        chk("pin_be_0x13", e_be[tc+1], 64'h08);
        chk("pin_ack_0x13", 64'(e_ack.exists(tc+1+LAT)), 64'd1);
      end
      1: for (int k = 0; k < 4; k++) chk("pin_wrap4_addr", e_addr[tc+1+k], wa[k]);
      2: begin
        chk("pin_err_0x2", 64'(e_err.exists(tc+1)), 64'd1);
        chk("pin_noreq_0x2", 64'(e_req.exists(tc+1)), 64'd0);
      end
      3: t3 = tc;
      4: begin
        chk("pin_b2b_accept", 64'(tc), 64'(t3 + 4));
        for (int c = t3 + 1 + LAT; c <= t3 + 8 + LAT; c++)
          chk("pin_b2b_ack", 64'(e_ack.exists(c)), 64'd1);
      end
`ifdef SPRAM_BRIDGE_RANGE_CHECK_EN
      5: chk("pin_range_err", 64'(e_err.exists(tc+1)), 64'd1);
      6: chk("pin_range_ok", 64'(e_ack.exists(tc+1+LAT)), 64'd1);
`endif
      default: ;
    endcase
  endtask

  task automatic kill_from(input int from);
    for (int k = from; k < from + 64; k++) begin
      if (e_req.exists(k))  e_req.delete(k);
      if (e_dack.exists(k)) e_dack.delete(k);
      if (e_err.exists(k))  e_err.delete(k);
      if (e_ack.exists(k))  e_ack.delete(k);
      if (e_qv.exists(k))   e_qv.delete(k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    ram_q_i = q_sched.exists(cyc) ? q_sched[cyc] : {$urandom, $urandom};
  endtask

  task automatic drive_idle();
    biu_stb_i  = 1'b0;
    biu_adri_i = {$urandom, $urandom};
    biu_size_i = 3'($urandom);
    biu_type_i = 3'($urandom);
    biu_we_i   = 1'($urandom);
    biu_prot_i = 3'($urandom);
    biu_lock_i = 1'($urandom);
    biu_d_i    = d_plan.exists(cyc) ? d_plan[cyc] : {$urandom, $urandom};
  endtask

  task automatic drive_txn(input txn_t t);
    biu_stb_i  = 1'b1;
    biu_adri_i = t.addr;
    biu_size_i = t.size;
    biu_type_i = t.hb;
    biu_we_i   = t.we;
    biu_d_i    = d_plan.exists(cyc) ? d_plan[cyc] : t.data[0];
  endtask

  function automatic txn_t mk(input int id, input logic [63:0] a, input logic [2:0] sz,
                              input logic [2:0] hb, input logic we);
    txn_t t;
    t.id = 32'(id); t.addr = a; t.size = sz; t.hb = hb; t.we = we;
    for (int j = 0; j < 16; j++) t.data[j] = {$urandom, $urandom};
    return t;
  endfunction

  // compare + SPRAM model
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("ram_req", 64'(ram_req_o), 64'(e_req.exists(cyc)));
      if (e_req.exists(cyc)) begin
        chk("ram_addr", ram_addr_o, e_addr[cyc]);
        chk("ram_be", 64'(ram_be_o), e_be[cyc]);
        chk("ram_we", 64'(ram_we_o), e_we[cyc]);
        if (e_we[cyc][0]) chk("ram_d", ram_d_o, e_wd[cyc]);
      end
      chk("d_ack", 64'(biu_d_ack_o), 64'(e_dack.exists(cyc)));
      chk("stb_ack", 64'(biu_stb_ack_o), 64'(e_sack.exists(cyc)));
      chk("err", 64'(biu_err_o), 64'(e_err.exists(cyc)));
      chk("ack", 64'(biu_ack_o), 64'(e_ack.exists(cyc)));
      if (e_ack.exists(cyc)) chk("adro", biu_adro_o, e_adro[cyc]);
      if (e_qv.exists(cyc))  chk("rdata", biu_q_o, e_q[cyc]);
      if (rst) begin
        chk("rst_addr", ram_addr_o, 64'd0);
        chk("rst_be", 64'(ram_be_o), 64'd0);
        chk("rst_d", ram_d_o, 64'd0);
        chk("rst_adro", biu_adro_o, 64'd0);
      end
      if (!rst && ram_req_o) begin
        ridx = int'(ram_addr_o[12:3]);
        if (ram_we_o) begin
          for (int b = 0; b < 8; b++)
            if (ram_be_o[b]) ram_mem[ridx][b*8 +: 8] = ram_d_o[b*8 +: 8];
        end else q_sched[cyc+LAT] = ram_mem[ridx];
      end
    end
  end

  initial begin
    int tr;
    txn_t t;
    for (int i = 0; i < 1024; i++) begin ref_mem[i] = '0; ram_mem[i] = '0; end
    rst = 1'b1;
    ram_q_i = '0;
    drive_idle();
    biu_stb_i = 1'b0;

    q.push_back(mk(0, 64'h13, 3'd0, 3'd0, 1'b1));
    q[0].data[0] = 64'hAB << 24;
    q.push_back(mk(1, 64'h18, 3'd3, 3'd2, 1'b0));
    q.push_back(mk(2, 64'h02, 3'd2, 3'd0, 1'b0));
    q.push_back(mk(3, 64'h40, 3'd3, 3'd3, 1'b0));
    q.push_back(mk(4, 64'h80, 3'd3, 3'd3, 1'b0));
    q.push_back(mk(5, 64'h1000, 3'd3, 3'd0, 1'b0));
    q.push_back(mk(6, 64'hFF8, 3'd3, 3'd0, 1'b0));
    q.push_back(mk(7, 64'h10, 3'd3, 3'd0, 1'b0));
    for (int i = 0; i < 220; i++) begin
      tr = int'($urandom_range(0, 9));
      t = mk(100 + i, 64'($urandom_range(0, 'h1FFF)),
             (tr < 8) ? 3'(tr % 4) : 3'($urandom_range(4, 7)),
             3'($urandom_range(0, 7)), 1'($urandom));
      if ($urandom_range(0, 4) != 0 && t.size < 3'd4)
        t.addr = t.addr & ~((64'd1 << t.size) - 64'd1);
      q.push_back(t);
    end

    repeat (3) step();
    rst = 1'b0;
    next_free = cyc + 1;

    while ((q.size() > 0 || pending) && cyc < 20000) begin
      step();
      if (!pending && gap == 0 && q.size() > 0) begin
        cur = q.pop_front();
        pending = 1;
      end else if (gap > 0) gap--;
      if (pending) drive_txn(cur);
      else drive_idle();
      if (pending && cyc >= next_free) begin
        model_accept(cur, cyc);
        pins(cur, cyc);
        pending = 0;
        gap = (cur.id < 100) ? 0 : int'($urandom_range(0, 2));
      end
    end
    chk("timeout_left", 64'(q.size()), 64'd0);

    repeat (30) begin step(); drive_idle(); end

    // reset during beat 3 of an INCR8 read
    step();
    cur = mk(9, 64'h100, 3'd3, 3'd5, 1'b0);
    drive_txn(cur);
    tr = cyc;
    model_accept(cur, cyc);
    step(); drive_idle();
    step(); drive_idle();
    step(); drive_idle();
    rst = 1'b1;
    kill_from(tr + 3);
    repeat (2) begin step(); drive_idle(); end
    rst = 1'b0;
    next_free = cyc + 1;
    repeat (30) begin step(); drive_idle(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
